// File: rtl/ddr4_axi_rds_pkg.sv
// ddr4_axi_rds_pkg: shared types and constants for the AXI R-channel downsizer
`timescale 1ns/1ps
package ddr4_axi_rds_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int lane_width(input int ratio);
    return ratio > 1 ? $clog2(ratio) : 1;
  endfunction
endpackage

// File: rtl/ddr4_axi_rds_lane_mux.sv
// ddr4_axi_rds_lane_mux: selects one narrow lane out of a wide data word
`timescale 1ns/1ps
module ddr4_axi_rds_lane_mux
  import ddr4_axi_rds_pkg::*;
#(
  parameter int C_S_DATA_WIDTH = 32,
  parameter int C_M_DATA_WIDTH = 128,
  localparam int C_RATIO = C_M_DATA_WIDTH / C_S_DATA_WIDTH,
  localparam int C_RATIO_LOG = lane_width(C_RATIO)
) (
  input  logic [C_M_DATA_WIDTH-1:0] data,
  input  logic [C_RATIO_LOG-1:0]    lane,
  output logic [C_S_DATA_WIDTH-1:0] slice
);
  logic [C_S_DATA_WIDTH-1:0] lanes [C_RATIO];
  for (genvar i = 0; i < C_RATIO; i++) begin : g_lane
    assign lanes[i] = data[i*C_S_DATA_WIDTH +: C_S_DATA_WIDTH];
  end
  assign slice = lanes[lane];
endmodule

// File: rtl/ddr4_axi_r_downsizer.sv
// ddr4_axi_r_downsizer: splits wide memory-side R beats into narrow master-side beats per burst command
// Define DDR4_AXI_RDS_LAST_CHECK_EN to build the sticky wide-RLAST consistency check.
`timescale 1ns/1ps
module ddr4_axi_r_downsizer
  import ddr4_axi_rds_pkg::*;
#(
  parameter C_FAMILY = "virtexuplus",
  parameter int C_S_DATA_WIDTH = 32,
  parameter int C_M_DATA_WIDTH = 128,
  parameter int C_ID_WIDTH = 4,
  localparam int C_RATIO = C_M_DATA_WIDTH / C_S_DATA_WIDTH,
  localparam int C_RATIO_LOG = lane_width(C_RATIO)
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [C_RATIO_LOG-1:0]    cmd_lane,
  input  logic [7:0]                cmd_len,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  input  logic [C_M_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_RID,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [C_S_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic [C_ID_WIDTH-1:0]     S_AXI_RID,
  output logic                      err_last_mismatch
);
  localparam logic [C_RATIO_LOG-1:0] LAST_LANE = C_RATIO_LOG'(C_RATIO - 1);
  state_t state, state_n;
  logic [C_RATIO_LOG-1:0] lane_q, lane_n;
  logic [7:0] beats_q, beats_n;
  logic [C_M_DATA_WIDTH-1:0] hold_data;
  logic [1:0] hold_resp;
  logic [C_ID_WIDTH-1:0] hold_id;
  logic wide_hs, narrow_hs;
  // cmd_ready is gated by reset so it reads 0 while ARESETN is held low
  assign cmd_ready = ARESETN && state == IDLE;
  assign M_AXI_RREADY = state == FETCH;
  assign S_AXI_RVALID = state == EMIT;
  assign S_AXI_RRESP = hold_resp;
  assign S_AXI_RID = hold_id;
  assign S_AXI_RLAST = S_AXI_RVALID && beats_q == 8'd0;
  assign wide_hs = M_AXI_RREADY && M_AXI_RVALID;
  assign narrow_hs = S_AXI_RVALID && S_AXI_RREADY;
  ddr4_axi_rds_lane_mux #(
    .C_S_DATA_WIDTH(C_S_DATA_WIDTH),
    .C_M_DATA_WIDTH(C_M_DATA_WIDTH)
  ) u_lane_mux (
    .data (hold_data),
    .lane (lane_q),
    .slice(S_AXI_RDATA)
  );
  always_comb begin
    state_n = state;
    lane_n = lane_q;
    beats_n = beats_q;
    if (cmd_ready && cmd_valid) begin
      state_n = FETCH;
      lane_n = cmd_lane;
      beats_n = cmd_len;
    end
    if (wide_hs) state_n = EMIT;
    if (narrow_hs) begin
      state_n = beats_q == 8'd0 ? IDLE : lane_q == LAST_LANE ? FETCH : EMIT;
      lane_n = lane_q == LAST_LANE ? '0 : lane_q + 1'b1;
      beats_n = beats_q == 8'd0 ? beats_q : beats_q - 8'd1;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      lane_q <= '0;
      beats_q <= '0;
      hold_data <= '0;
      hold_resp <= RESP_OKAY;
      hold_id <= '0;
    end else begin
      state <= state_n;
      lane_q <= lane_n;
      beats_q <= beats_n;
      if (wide_hs) begin
        hold_data <= M_AXI_RDATA;
        hold_resp <= M_AXI_RRESP;
        hold_id <= M_AXI_RID;
      end
    end
  end
`ifdef DDR4_AXI_RDS_LAST_CHECK_EN
  // the word being fetched is the burst's last when the remaining beats fit in its lanes
  logic final_word;
  assign final_word = 9'(beats_q) + 9'(lane_q) < 9'(C_RATIO);
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) err_last_mismatch <= 1'b0;
    else if (wide_hs && M_AXI_RLAST != final_word) err_last_mismatch <= 1'b1;
  end
`else
  assign err_last_mismatch = 1'b0;
`endif
endmodule
